// File: rtl/clock_div_sweeper.sv
// Sweeps the clock manager CLKOUT0 integer divide and samples the measured frequency.
// Optional CLK_SWEEP_RESTORE_EN reprograms div_restore before signalling done.
module clock_div_sweeper #(
    parameter int unsigned FREQ_HZ        = 250000000,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned MEASURE_CYCLES = FREQ_HZ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  div_first,
    input  logic [7:0]  div_last,
    input  logic [7:0]  div_step,
    input  logic [9:0]  div_frac,
    input  logic [31:0] div_restore,
    input  logic [31:0] freq_out,
    output logic [31:0] div_in,
    output logic        configure,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        sample_valid,
    output logic [7:0]  sample_div,
    output logic [31:0] sample_freq,
    output logic [8:0]  sample_count
);

    localparam logic [31:0] SET_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] MEAS_LAST = 32'(MEASURE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PROGRAM, S_SETTLE, S_MEASURE, S_NEXT,
        S_FINISH, S_RESTORE, S_RSETTLE, S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [7:0]  cur_q, last_q, step_q;
    logic [9:0]  frac_q;
    logic [31:0] div_in_q, sample_freq_q;
    logic        configure_q, busy_q, done_q, aborted_q, sample_valid_q;
    logic [7:0]  sample_div_q;
    logic [8:0]  sample_count_q;
    logic [8:0]  nxt_d;
    logic        sweeping;

`ifdef CLK_SWEEP_RESTORE_EN
    logic [31:0] restore_q;
`else
    logic        unused_restore;
    assign unused_restore = ^div_restore;
`endif

    // 9-bit sum so a step past 255 terminates instead of wrapping
    assign nxt_d = {1'b0, cur_q} + {1'b0, step_q};
    assign sweeping = (state_q == S_PROGRAM) || (state_q == S_SETTLE) ||
                      (state_q == S_MEASURE) || (state_q == S_NEXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            cur_q          <= '0;
            last_q         <= '0;
            step_q         <= '0;
            frac_q         <= '0;
            div_in_q       <= '0;
            sample_freq_q  <= '0;
            configure_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_div_q   <= '0;
            sample_count_q <= '0;
`ifdef CLK_SWEEP_RESTORE_EN
            restore_q      <= '0;
`endif
        end else begin
            configure_q    <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            if (abort && sweeping) begin
                state_q   <= S_FINISH;
                aborted_q <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            cur_q          <= div_first;
                            last_q         <= div_last;
                            step_q         <= (div_step == 8'd0) ? 8'd1 : div_step;
                            frac_q         <= div_frac;
                            aborted_q      <= 1'b0;
                            sample_count_q <= '0;
`ifdef CLK_SWEEP_RESTORE_EN
                            restore_q      <= div_restore;
`endif
                            if (div_first == 8'd0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_PROGRAM;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_PROGRAM: begin
                        div_in_q    <= {14'b0, frac_q, cur_q};
                        configure_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt_q == SET_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_MEASURE;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_MEASURE: begin
                        if (cnt_q == MEAS_LAST) begin
                            sample_freq_q  <= freq_out;
                            sample_div_q   <= cur_q;
                            sample_valid_q <= 1'b1;
                            sample_count_q <= sample_count_q + 9'd1;
                            state_q        <= S_NEXT;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_NEXT: begin
                        if (nxt_d[8] || (nxt_d[7:0] > last_q)) begin
                            state_q <= S_FINISH;
                        end else begin
                            cur_q   <= nxt_d[7:0];
                            state_q <= S_PROGRAM;
                        end
                    end
`ifdef CLK_SWEEP_RESTORE_EN
                    S_FINISH: state_q <= S_RESTORE;
                    S_RESTORE: begin
                        div_in_q    <= restore_q;
                        configure_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_RSETTLE;
                    end
                    S_RSETTLE: begin
                        if (cnt_q == SET_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
`else
                    S_FINISH: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
`endif
                    S_DONE: state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign div_in       = div_in_q;
    assign configure    = configure_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign sample_valid = sample_valid_q;
    assign sample_div   = sample_div_q;
    assign sample_freq  = sample_freq_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_clock_div_sweeper.sv
// Directed bench for clock_div_sweeper with a 1e9/int frequency model.
module tb_clock_div_sweeper;

    localparam int SC = 64;
    localparam int MC = 100;
`ifdef CLK_SWEEP_RESTORE_EN
    localparam int RX = 1;
`else
    localparam int RX = 0;
`endif

    logic        clk, reset, start, abort;
    logic [7:0]  div_first, div_last, div_step;
    logic [9:0]  div_frac;
    logic [31:0] div_restore, freq_out, div_in, sample_freq;
    logic        configure, busy, done, aborted, sample_valid;
    logic [7:0]  sample_div;
    logic [8:0]  sample_count;

    clock_div_sweeper #(
        .FREQ_HZ(250000000), .SETTLE_CYCLES(SC), .MEASURE_CYCLES(MC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .div_first(div_first), .div_last(div_last), .div_step(div_step),
        .div_frac(div_frac), .div_restore(div_restore), .freq_out(freq_out),
        .div_in(div_in), .configure(configure), .busy(busy), .done(done),
        .aborted(aborted), .sample_valid(sample_valid),
        .sample_div(sample_div), .sample_freq(sample_freq),
        .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb
        freq_out = (div_in[7:0] == 8'd0) ? 32'd0 :
                   32'(1000000000 / int'(div_in[7:0]));

    logic [31:0] cfg_q[$];
    logic [7:0]  sd_q[$];
    logic [31:0] sf_q[$];
    int n_done = 0;
    int d0 = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(negedge clk) begin
        if (configure) cfg_q.push_back(div_in);
        if (sample_valid) begin
            sd_q.push_back(sample_div);
            sf_q.push_back(sample_freq);
        end
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sweep(input logic [7:0] f, input logic [7:0] l,
                         input logic [7:0] s, input logic [9:0] fr);
        cfg_q.delete();
        sd_q.delete();
        sf_q.delete();
        d0 = n_done;
        div_first = f;
        div_last = l;
        div_step = s;
        div_frac = fr;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20000 && n_done == d0; i++) tick(1);
        check(tag, 32'(n_done > d0), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        div_first = '0;
        div_last = '0;
        div_step = '0;
        div_frac = '0;
        div_restore = 32'h0000_0205;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_div_in", div_in, 32'd0);
        check("rst_cfg", 32'(configure), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(sample_count), 32'd0);
        reset = 1'b0;
        tick(2);

        // 4..8 step 2
        sweep(8'd4, 8'd8, 8'd2, 10'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done("s1_done_seen");
        tick(3);
        check("s1_ncfg", cfg_q.size(), 32'(3 + RX));
        if (cfg_q.size() >= 3) begin
            check("s1_cfg0", cfg_q[0], 32'h004);
            check("s1_cfg1", cfg_q[1], 32'h006);
            check("s1_cfg2", cfg_q[2], 32'h008);
        end
        check("s1_nsmp", sd_q.size(), 32'd3);
        if (sd_q.size() >= 3) begin
            check("s1_div0", 32'(sd_q[0]), 32'd4);
            check("s1_div2", 32'(sd_q[2]), 32'd8);
            check("s1_f0", sf_q[0], 32'd250000000);
            check("s1_f1", sf_q[1], 32'd166666666);
            check("s1_f2", sf_q[2], 32'd125000000);
        end
        check("s1_ndone", 32'(n_done - d0), 32'd1);
        check("s1_count", 32'(sample_count), 32'd3);
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_aborted", 32'(aborted), 32'd0);

        // first > last, step 0
        sweep(8'd10, 8'd5, 8'd0, 10'h3FF);
        wait_done("s2_done_seen");
        tick(3);
        if (cfg_q.size() >= 1) check("s2_cfg0", cfg_q[0], 32'h0003_FF0A);
        check("s2_nsmp", sd_q.size(), 32'd1);
        if (sd_q.size() >= 1) begin
            check("s2_div", 32'(sd_q[0]), 32'd10);
            check("s2_f", sf_q[0], 32'd100000000);
        end
        check("s2_aborted", 32'(aborted), 32'd0);

        // no wrap past 255
        sweep(8'd250, 8'd255, 8'd4, 10'd0);
        wait_done("s3_done_seen");
        tick(3);
        check("s3_nsmp", sd_q.size(), 32'd2);
        if (sd_q.size() >= 2) begin
            check("s3_div0", 32'(sd_q[0]), 32'd250);
            check("s3_div1", 32'(sd_q[1]), 32'd254);
            check("s3_f1", sf_q[1], 32'd3937007);
        end
        check("s3_count", 32'(sample_count), 32'd2);

        // abort 20 cycles into the second SETTLE
        begin
            int k;
            k = 0;
            sweep(8'd4, 8'd8, 8'd2, 10'd0);
            for (int i = 0; i < 2000 && k < 2; i++) begin
                tick(1);
                if (configure) k++;
            end
            check("s4_two_cfg", 32'(k), 32'd2);
            tick(19);
            abort = 1'b1;
            tick(1);
            abort = 1'b0;
            check("s4_aborted", 32'(aborted), 32'd1);
`ifndef CLK_SWEEP_RESTORE_EN
            tick(1);
            check("s4_done_2cyc", 32'(done), 32'd1);
`endif
            wait_done("s4_done_seen");
            tick(3);
            check("s4_nsmp", sd_q.size(), 32'd1);
            check("s4_count", 32'(sample_count), 32'd1);
            check("s4_busy", 32'(busy), 32'd0);
        end

        // first == 0
        sweep(8'd0, 8'd8, 8'd1, 10'd0);
        check("s5_done_1cyc", 32'(done), 32'd1);
        check("s5_aborted_clr", 32'(aborted), 32'd0);
        tick(3);
        check("s5_ncfg", cfg_q.size(), 32'd0);
        check("s5_count", 32'(sample_count), 32'd0);
        check("s5_ndone", 32'(n_done - d0), 32'd1);

        // start together with abort is ignored
        d0 = n_done;
        div_first = 8'd4;
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("s6_busy", 32'(busy), 32'd0);
        tick(5);
        check("s6_idle", 32'(busy), 32'd0);
        check("s6_ndone", 32'(n_done - d0), 32'd0);

`ifdef CLK_SWEEP_RESTORE_EN
        begin
            int c_cfg, c_done;
            c_cfg = -1;
            c_done = -1;
            sweep(8'd4, 8'd4, 8'd1, 10'd0);
            for (int i = 0; i < 2000 && c_done < 0; i++) begin
                tick(1);
                if (configure && div_in == 32'h205) c_cfg = i;
                if (done) c_done = i;
            end
            check("s7_restore_seen", 32'(c_cfg >= 0), 32'd1);
            check("s7_settle_gap", 32'(c_done - c_cfg), 32'(SC));
            check("s7_div_in", div_in, 32'h205);
            tick(2);
        end
`endif

        // async reset during MEASURE
        begin
            int ncfg;
            sweep(8'd4, 8'd8, 8'd2, 10'd0);
            tick(SC + 20);
            reset = 1'b1;
            #1;
            check("s8_busy", 32'(busy), 32'd0);
            check("s8_div_in", div_in, 32'd0);
            tick(1);
            reset = 1'b0;
            ncfg = cfg_q.size();
            tick(400);
            check("s8_ndone", 32'(n_done - d0), 32'd0);
            check("s8_ncfg", 32'(cfg_q.size() - ncfg), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
